// File: rtl/cfg_reg_pkg.sv
// Shared config-register types: filter rule layout, rule field selects and commit FSM states.
// Also holds the helper that applies one field write to a rule.
package cfg_reg_pkg;

  typedef struct packed {
    logic [31:0]  ipv4_addr;
    logic [127:0] ipv6_addr;
    logic [15:0]  port;
  } filter_rule_t;

  typedef enum logic [1:0] {
    FLD_IPV4 = 2'd0,
    FLD_IPV6 = 2'd1,
    FLD_PORT = 2'd2
  } rule_field_e;

  localparam logic [1:0] FLD_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BND = 2'd1,
    SWAP     = 2'd2
  } commit_state_e;

  // Narrow fields take the LSBs of the 128-bit write data.
  function automatic filter_rule_t rule_set_field(input filter_rule_t r,
                                                  input logic [1:0]   fld,
                                                  input logic [127:0] d);
    filter_rule_t res;
    res = r;
    case (fld)
      FLD_IPV4: res.ipv4_addr = d[31:0];
      FLD_IPV6: res.ipv6_addr = d;
      FLD_PORT: res.port      = d[15:0];
      default:  res           = r;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/filter_rule_commit_ctrl_axis_pkt_tracker.sv
// Tracks whether an AXI-stream packet is open from tvalid/tready/tlast taps.
// in_pkt_nxt_o is the state after this cycle's beat; pure observer, never stalls the stream.
module axis_pkt_tracker (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tvalid_i,
  input  logic tready_i,
  input  logic tlast_i,
  output logic in_pkt_o,
  output logic in_pkt_nxt_o
);

  logic in_pkt_q;
  logic in_pkt_d;
  logic beat;

  assign beat = tvalid_i & tready_i;

  always_comb begin
    in_pkt_d = in_pkt_q;
    if (beat) begin
      in_pkt_d = ~tlast_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_pkt_q <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
    end
  end

  assign in_pkt_o     = in_pkt_q;
  assign in_pkt_nxt_o = in_pkt_d;

endmodule

// File: rtl/filter_rule_commit_ctrl.sv
// Shadow/active filter rule store; commit swaps shadow into active at an RX packet boundary.
// Swap lands 1 cycle after commit (or after the closing tlast beat); hold stalls RX during that cycle.
module filter_rule_commit_ctrl
  import cfg_reg_pkg::*;
#(
  parameter int NUM_RULES = 2,
  parameter int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [1:0]         wr_field,
  input  logic [127:0]       wr_data,
  input  logic               commit_valid,
  output logic               commit_ready,
  input  logic               mon_tvalid,
  input  logic               mon_tready,
  input  logic               mon_tlast,
  output logic               hold,
  output filter_rule_t       active_rules [NUM_RULES],
  output logic               busy,
  output logic [15:0]        commit_count,
  output logic [7:0]         err_count
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WAIT_BND = WAIT_BND;
  localparam logic [1:0] ST_SWAP     = SWAP;

  logic [1:0]   state_q, state_d;
  filter_rule_t shadow_q [NUM_RULES];
  filter_rule_t shadow_d [NUM_RULES];
  filter_rule_t active_q [NUM_RULES];
  filter_rule_t active_d [NUM_RULES];
  logic [15:0]  commit_count_q, commit_count_d;
  logic [7:0]   err_count_q, err_count_d;
  logic         busy_q;

  logic in_pkt;
  logic in_pkt_nxt;
  logic wr_hs;
  logic commit_hs;
  logic wr_bad;

  axis_pkt_tracker u_pkt_tracker (
    .clk_i        (aclk),
    .rst_i        (areset),
    .tvalid_i     (mon_tvalid),
    .tready_i     (mon_tready),
    .tlast_i      (mon_tlast),
    .in_pkt_o     (in_pkt),
    .in_pkt_nxt_o (in_pkt_nxt)
  );

  // Handshake outputs decode from state only so upstream valid never loops back into ready.
  assign wr_ready     = (state_q == ST_IDLE);
  assign commit_ready = (state_q == ST_IDLE);
  assign hold         = (state_q == ST_SWAP);

  assign wr_hs     = wr_valid & wr_ready;
  assign commit_hs = commit_valid & commit_ready;
  assign wr_bad    = ({1'b0, wr_idx} >= (IDX_W + 1)'(NUM_RULES)) || (wr_field == FLD_RSVD);

  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (wr_hs && !wr_bad && (wr_idx == IDX_W'(i))) begin
        shadow_d[i] = rule_set_field(shadow_q[i], wr_field, wr_data);
      end
    end
  end

  // The swap copies shadow_q, so a write accepted alongside the commit is already in it.
  always_comb begin
    active_d = active_q;
    if (state_q == ST_SWAP) begin
      active_d = shadow_q;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (wr_hs && wr_bad && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_comb begin
    state_d        = state_q;
    commit_count_d = commit_count_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_hs) begin
          state_d = in_pkt_nxt ? ST_WAIT_BND : ST_SWAP;
        end
      end
      ST_WAIT_BND: begin
        if (!in_pkt_nxt) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        state_d        = ST_IDLE;
        commit_count_d = commit_count_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= ST_IDLE;
      commit_count_q <= '0;
      err_count_q    <= '0;
      busy_q         <= 1'b0;
      for (int i = 0; i < NUM_RULES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      commit_count_q <= commit_count_d;
      err_count_q    <= err_count_d;
      busy_q         <= (state_d != ST_IDLE);
      shadow_q       <= shadow_d;
      active_q       <= active_d;
    end
  end

  assign active_rules = active_q;
  assign busy         = busy_q;
  assign commit_count = commit_count_q;
  assign err_count    = err_count_q;

  // A commit only waits while a packet is actually open.
  assert property (@(posedge aclk) disable iff (areset)
    (state_q == ST_WAIT_BND) |-> in_pkt);

endmodule

// File: doc/filter_rule_commit_ctrl.md
# filter_rule_commit_ctrl

Controller that owns the active filter rule set driven into `filter_rx_pipeline` (`cfg_reg.filter_rules`). Software-side writes land in a shadow copy. A commit request swaps shadow into active only at a packet boundary on the pipeline's RX input, so every packet is classified against one consistent rule set. It sits between the control-register block and `filter_rx_pipeline` in the RX path.

## Interface
- `NUM_RULES`, 2, number of filter rules (must match `filter_rx_pipeline`).
- `IDX_W`, `$clog2(NUM_RULES)` min 1, width of rule index.

Ports:
- `aclk` in 1: single clock.
- `areset` in 1: reset; synchronous, active-high.
- `wr_valid` in 1: rule-field write request.
- `wr_ready` out 1: write accepted when high with `wr_valid`.
- `wr_idx` in `IDX_W`: target rule.
- `wr_field` in 2: field select; 0 = ipv4_addr, 1 = ipv6_addr, 2 = port, 3 = reserved.
- `wr_data` in 128: field value; LSBs are used for 32-bit fields.
- `commit_valid` in 1: request shadow-to-active swap.
- `commit_ready` out 1: commit accepted.
- `mon_tvalid`, `mon_tready`, `mon_tlast` in 1 each: taps of the pipeline's `s_axis_*` handshake.
- `hold` out 1: top level ANDs `!hold` into the upstream tready, blocking new beats during the swap.
- `active_rules` out `filter_rule_t [NUM_RULES]`: rules driven to the pipeline.
- `busy` out 1: commit pending or in progress.
- `commit_count` out 16: completed commits, wraps.
- `err_count` out 8: dropped writes, saturating at 255.

## Operation
- Shadow and active rule arrays are registered. `active_rules` changes only in SWAP.
- `in_pkt` tracker:
  - A beat is `mon_tvalid & mon_tready`.
  - A beat with `!tlast` sets `in_pkt`; a beat with `tlast` clears it.
  - `in_pkt_nxt` is the value after the current cycle's beat.
- FSM states: IDLE, WAIT_BND, SWAP.
- IDLE:
  - `wr_ready` = 1 and `commit_ready` = 1.
  - On commit handshake: go to SWAP if `in_pkt_nxt` = 0, else go to WAIT_BND.
- WAIT_BND:
  - `wr_ready` = 0 and `commit_ready` = 0; `busy` = 1.
  - Go to SWAP on the first cycle where `in_pkt_nxt` = 0.
- SWAP (exactly 1 cycle):
  - `hold` = 1 and `busy` = 1.
  - active ← shadow at the end of the cycle; `commit_count` += 1.
  - Return to IDLE.
- Write handshake: shadow[`wr_idx`].field ← `wr_data` at the next edge.
- Invalid writes (`wr_idx` ≥ `NUM_RULES`, or `wr_field` = 3):
  - The write is accepted and then dropped; no shadow change.
  - `err_count` += 1, saturating.
- A write and a commit in the same IDLE cycle: the write is included in that commit.
- Shadow is never cleared by a commit. Unwritten fields keep their prior shadow value.
- `commit_valid` outside IDLE is simply not accepted; no error is counted.

## Timing
- Reset, applied synchronously from any state:
  - state = IDLE, `in_pkt` = 0.
  - shadow = 0, `active_rules` = 0.
  - `commit_count` = 0, `err_count` = 0.
  - `hold` = 0, `busy` = 0, `wr_ready` = 1, `commit_ready` = 1.
- Reset during WAIT_BND or SWAP abandons the commit; active stays 0.
- Write latency: shadow updated 1 edge after the handshake.
- Commit latency, with no packet in flight: handshake at cycle N, SWAP at N+1, new `active_rules` visible from N+2.
- Commit latency, mid-packet: the tlast beat occurs at cycle M, SWAP at M+1, new rules visible from M+2.
- `hold` is asserted only in SWAP. Therefore no beat is accepted in the swap cycle, and a packet's first beat always sees the old or the new set in full.
- If a tlast beat and a commit handshake fall in the same cycle, the FSM goes directly to SWAP.
- A back-to-back packet (tlast then a first beat on the next cycle) is still cut by SWAP via `hold`.
- All outputs are registered except `wr_ready`, `commit_ready` and `hold`, which decode from the state register only (no input-to-output combinational path).

## Structure
- Add to `cfg_reg_pkg`:
  - `rule_field_e` (FLD_IPV4 = 0, FLD_IPV6 = 1, FLD_PORT = 2).
  - `commit_state_e` (IDLE, WAIT_BND, SWAP).
  - Reuse the existing `filter_rule_t`.
- One sub-module: `axis_pkt_tracker`. It takes the tvalid/tready/tlast taps and outputs `in_pkt` and `in_pkt_nxt`. It is reused by other RX-side controllers.

## Test plan
- Idle commit: write rule0 ipv4 = C0A80001 and port = 0x50, then commit with no traffic. Required: `active_rules[0]` matches from commit+2 cycles, `commit_count` = 1, `hold` pulses for 1 cycle.
- Mid-packet commit: start a 4-beat packet, commit after beat 1. Required: `busy` = 1 and `wr_ready` = 0 until beat 4 (tlast); active changes 2 cycles after the tlast beat; beat-4 data is unaffected by the swap.
- Invalid writes: `wr_idx` = 2 with `NUM_RULES` = 2, then `wr_field` = 3. Required: shadow and active unchanged after a commit; `err_count` = 2. Drive 300 bad writes: `err_count` holds at 255.
- Simultaneous write and commit: write rule1 port = 0x1BB in the same cycle as the commit handshake. Required: `active_rules[1].port` = 0x1BB after SWAP.
- Reset in WAIT_BND: assert `areset` for 1 cycle mid-packet. Required: state IDLE, `active_rules` = 0, `commit_count` = 0, `busy` = 0 on the next cycle; a subsequent commit works normally.
- Back-to-back packets: continuous traffic with a commit pending. Required: `hold` is high exactly in the cycle after the tlast beat, and no beat is accepted in that cycle.
